tournament_predictor: RTL

TOURNAMENT_PREDICTOR -- requirements
Module: tournament_predictor

---
 rtl/bp_pkg.sv | 31 +++
 rtl/bp_ckpt_fifo.sv | 68 ++++++
 rtl/tournament_predictor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, counter thresholds and saturating helpers for the branch predictor
package bp_pkg;
   localparam int BP_GHR_W       = 8;
   localparam int BP_LHT_ENTRIES = 64;
   localparam int BP_LHT_IW      = $clog2(BP_LHT_ENTRIES);
   localparam int BP_LHR_W       = 8;
   localparam int BP_CTR_W       = 2;

   localparam logic [BP_CTR_W-1:0] CTR_ONE      = BP_CTR_W'(1);
   localparam logic [BP_CTR_W-1:0] CTR_MAX      = '1;
   localparam logic [BP_CTR_W-1:0] CTR_TAKEN_TH = BP_CTR_W'(1 << (BP_CTR_W - 1));
   localparam logic [BP_CTR_W-1:0] CTR_WEAK_NT  = BP_CTR_W'((1 << (BP_CTR_W - 1)) - 1);

   typedef struct packed {
      logic [BP_GHR_W-1:0]  gidx;
      logic [BP_LHT_IW-1:0] lidx;
      logic [BP_LHR_W-1:0]  lhist;
      logic                 gpred;
      logic                 lpred;
      logic                 fpred;
      logic [BP_GHR_W-1:0]  ghr;
   } ckpt_t;

   function automatic logic [BP_CTR_W-1:0] sat_inc(input logic [BP_CTR_W-1:0] c);
      return (c == CTR_MAX) ? c : c + CTR_ONE;
   endfunction

   function automatic logic [BP_CTR_W-1:0] sat_dec(input logic [BP_CTR_W-1:0] c);
      return (c == '0) ? c : c - CTR_ONE;
   endfunction
endpackage

// File: rtl/bp_ckpt_fifo.sv
// rtl/bp_ckpt_fifo.sv - in-flight branch checkpoint FIFO with push/pop/clear
module bp_ckpt_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  push,
   input  logic  pop,
   input  logic  clear,
   input  ckpt_t din,
   output ckpt_t dout,
   output logic  full,
   output logic  empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   ckpt_t         mem_q [DEPTH];
   ckpt_t         mem_d [DEPTH];
   logic          push_ok, pop_ok;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign dout    = mem_q[rd_ptr_q];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end
endmodule

// File: rtl/tournament_predictor.sv
// rtl/tournament_predictor.sv - gshare/local tournament predictor with checkpointed history repair
// Statistics counters exist only when BP_STAT_EN is defined.
module tournament_predictor
   import bp_pkg::*;
#(
   parameter int GHR_W       = BP_GHR_W,
   parameter int LHT_ENTRIES = BP_LHT_ENTRIES,
   parameter int LHR_W       = BP_LHR_W,
   parameter int CTR_W       = BP_CTR_W,
   parameter int DEPTH       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        pred_valid,
   input  logic [31:0] pred_pc,
   output logic        pred_take,
   output logic        pred_ready,
   input  logic        res_valid,
   input  logic        res_taken,
   output logic        mispred,
   output logic [31:0] branch_count,
   output logic [31:0] miss_count
);
   localparam int GPHT_N = 1 << GHR_W;
   localparam int LPHT_N = 1 << LHR_W;
   localparam int LHT_IW = $clog2(LHT_ENTRIES);

   logic [GHR_W-1:0] ghr_q, ghr_d;
   logic [CTR_W-1:0] gpht_q [GPHT_N];
   logic [CTR_W-1:0] gpht_d [GPHT_N];
   logic [CTR_W-1:0] meta_q [GPHT_N];
   logic [CTR_W-1:0] meta_d [GPHT_N];
   logic [CTR_W-1:0] lpht_q [LPHT_N];
   logic [CTR_W-1:0] lpht_d [LPHT_N];
   logic [LHR_W-1:0] lht_q  [LHT_ENTRIES];
   logic [LHR_W-1:0] lht_d  [LHT_ENTRIES];

   logic [GHR_W-1:0]  pc_idx, gidx, res_midx;
   logic [LHT_IW-1:0] lidx;
   logic [LHR_W-1:0]  lhist;
   logic              gpred, lpred, sel_global;
   logic              fifo_full, fifo_empty, push, resolve;
   ckpt_t             new_ent, head;
   logic              unused_pc;

   assign unused_pc = ^{pred_pc[31:GHR_W+2], pred_pc[1:0]};

   assign pc_idx     = pred_pc[GHR_W+1:2];
   assign gidx       = ghr_q ^ pc_idx;
   assign lidx       = pred_pc[LHT_IW+1:2];
   assign lhist      = lht_q[lidx];
   assign gpred      = (gpht_q[gidx] >= CTR_TAKEN_TH);
   assign lpred      = (lpht_q[lhist] >= CTR_TAKEN_TH);
   assign sel_global = (meta_q[pc_idx] >= CTR_TAKEN_TH);
   assign pred_take  = sel_global ? gpred : lpred;
   assign pred_ready = ~fifo_full;

   assign resolve = res_valid & ~stall & ~fifo_empty;
   assign mispred = resolve & (res_taken != head.fpred);
   assign push    = pred_valid & pred_ready & ~stall & ~mispred;

   assign new_ent = '{gidx: gidx, lidx: lidx, lhist: lhist, gpred: gpred,
                      lpred: lpred, fpred: pred_take, ghr: ghr_q};

   // The meta index is the PC slice, recovered from the stored gshare index and history.
   assign res_midx = head.gidx ^ head.ghr;

   bp_ckpt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (resolve),
      .clear (mispred),
      .din   (new_ent),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      ghr_d  = ghr_q;
      gpht_d = gpht_q;
      lpht_d = lpht_q;
      meta_d = meta_q;
      lht_d  = lht_q;
      if (mispred)   ghr_d = {head.ghr[GHR_W-2:0], res_taken};
      else if (push) ghr_d = {ghr_q[GHR_W-2:0], pred_take};
      if (resolve) begin
         gpht_d[head.gidx]  = res_taken ? sat_inc(gpht_q[head.gidx])  : sat_dec(gpht_q[head.gidx]);
         lpht_d[head.lhist] = res_taken ? sat_inc(lpht_q[head.lhist]) : sat_dec(lpht_q[head.lhist]);
         lht_d[head.lidx]   = {lht_q[head.lidx][LHR_W-2:0], res_taken};
         if (head.gpred != head.lpred)
            meta_d[res_midx] = (head.gpred == res_taken) ? sat_inc(meta_q[res_midx])
                                                         : sat_dec(meta_q[res_midx]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghr_q <= '0;
         for (int i = 0; i < GPHT_N; i++) begin
            gpht_q[i] <= CTR_WEAK_NT;
            meta_q[i] <= CTR_TAKEN_TH;
         end
         for (int i = 0; i < LPHT_N; i++) lpht_q[i] <= CTR_WEAK_NT;
         for (int i = 0; i < LHT_ENTRIES; i++) lht_q[i] <= '0;
      end else begin
         ghr_q  <= ghr_d;
         gpht_q <= gpht_d;
         lpht_q <= lpht_d;
         meta_q <= meta_d;
         lht_q  <= lht_d;
      end
   end

`ifdef BP_STAT_EN
   logic [31:0] branch_cnt_q, branch_cnt_d, miss_cnt_q, miss_cnt_d;

   always_comb begin
      branch_cnt_d = branch_cnt_q + {31'b0, resolve};
      miss_cnt_d   = miss_cnt_q + {31'b0, mispred};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt_q <= '0;
         miss_cnt_q   <= '0;
      end else begin
         branch_cnt_q <= branch_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   assign branch_count = branch_cnt_q;
   assign miss_count   = miss_cnt_q;
`else
   assign branch_count = '0;
   assign miss_count   = '0;
`endif
endmodule
